// File: rtl/ft_fifo_pkg.sv
// Shared types and helpers for the FT600 staging FIFO.
// Address width helper plus the packed status bundle.
package ft_fifo_pkg;

  function automatic int fifo_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/ft_fifo_ram_2p.sv
// Two-port storage array for the FT600 FIFO.
// Synchronous write, asynchronous read, no reset.
module ft_fifo_ram_2p
  import ft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/v3_param_sync_fifo.sv
// Single-clock FIFO for FT600 USB RX/TX staging.
// Full-depth occupancy, thresholds, sticky errors, flush, std/FWFT read.
module v3_param_sync_fifo
  import ft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int FWFT = 0,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W + 1)'(AE_THRESH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("v3_param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("v3_param_sync_fifo: AF_THRESH out of range");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("v3_param_sync_fifo: AE_THRESH out of range");
  end

  logic [ADDR_W:0]       w_ptr;
  logic [ADDR_W:0]       r_ptr;
  logic [ADDR_W:0]       cnt;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  w_acc;
  logic                  r_acc;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] rd_data;
  fifo_status_t          st;

  // Flags come only from registered state, so no input-to-flag path.
  assign st.full         = (cnt == DEPTH_C);
  assign st.empty        = (cnt == '0);
  assign st.almost_full  = (cnt >= AF_C);
  assign st.almost_empty = (cnt <= AE_C);
  assign st.overflow     = ovf_q;
  assign st.underflow    = unf_q;

  assign w_acc  = w_en & ~st.full;
  assign r_acc  = r_en & ~st.empty;
  assign ram_we = w_acc & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (w_acc) begin
        w_ptr <= w_ptr + ONE;
      end
      if (r_acc) begin
        r_ptr <= r_ptr + ONE;
      end
      cnt <= cnt
           + {{ADDR_W{1'b0}}, w_acc}
           - {{ADDR_W{1'b0}}, r_acc};
      if (w_en & st.full) begin
        ovf_q <= 1'b1;
      end
      if (r_en & st.empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  ft_fifo_ram_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(w_ptr[ADDR_W-1:0]),
    .wdata(data_in),
    .raddr(r_ptr[ADDR_W-1:0]),
    .rdata(rd_data)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rv_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else if (clr) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        rv_q <= r_acc;
        if (r_acc) begin
          dout_q <= rd_data;
        end
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rv_q;
  end else begin : g_fwft
    assign data_out = rd_data;
    assign rd_valid = ~st.empty;
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
  assign count        = cnt;

endmodule

// File: tb/tb_v3_param_sync_fifo.sv
// Bench for v3_param_sync_fifo: standard and FWFT instances share stimulus
// and are checked against a queue-based model of the FIFO.
module tb_v3_param_sync_fifo;

  localparam int DW = 16;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          w_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          r_en = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic          rv0, rv1;
  logic          full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1;
  logic [3:0]    cnt0, cnt1;
  logic          ovf0, ovf1, unf0, unf1;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf, m_rv0;
  logic [DW-1:0] m_dout0;

  always #5 clk = ~clk;

  v3_param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0),
    .AF_THRESH(6), .AE_THRESH(1)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .rd_valid(rv0),
    .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  v3_param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1),
    .AF_THRESH(6), .AE_THRESH(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .rd_valid(rv1),
    .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  function automatic logic [5:0] exp_st();
    int sz = q.size();
    return {sz == DP, sz == 0, sz >= 6, sz <= 1, m_ovf, m_unf};
  endfunction

  function automatic logic [3:0] exp_cnt();
    return 4'(q.size());
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rv0 = 0;
    m_dout0 = '0;
  endfunction

  function automatic void model_edge(bit w, logic [DW-1:0] d, bit r, bit c);
    bit is_full = (q.size() == DP);
    bit is_empty = (q.size() == 0);
    if (c) begin
      model_reset();
      return;
    end
    if (w && is_full) m_ovf = 1;
    if (r && is_empty) m_unf = 1;
    m_rv0 = r && !is_empty;
    if (r && !is_empty) m_dout0 = q.pop_front();
    if (w && !is_full) q.push_back(d);
  endfunction

  task automatic cyc(bit w, logic [DW-1:0] d, bit r, bit c);
    w_en = w;
    data_in = d;
    r_en = r;
    clr = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    w_en = 0;
    r_en = 0;
    clr = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    model_reset();
    n_checks++;
    if ({full0, empty0, af0, ae0, ovf0, unf0} !== 6'b010100) begin
      n_errors++;
      $display("FAIL reset_std_flags: got %b expected 010100",
               {full0, empty0, af0, ae0, ovf0, unf0});
    end
    n_checks++;
    if ({dout0, rv0, cnt0} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_std_data: got %h/%b/%0d expected 0/0/0",
               dout0, rv0, cnt0);
    end
    n_checks++;
    if ({full1, empty1, af1, ae1, ovf1, unf1, rv1, cnt1} !== 11'b01010000000) begin
      n_errors++;
      $display("FAIL reset_fwft: got %b expected 01010000000",
               {full1, empty1, af1, ae1, ovf1, unf1, rv1, cnt1});
    end
    release_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DP; i++) begin
      cyc(1, DW'(i), 0, 0);
      n_checks++;
      if ({full0, empty0, af0, ae0, ovf0, unf0} !== exp_st() ||
          cnt0 !== exp_cnt()) begin
        n_errors++;
        $display("FAIL fill_std_%0d: got %b cnt %0d expected %b cnt %0d",
                 i, {full0, empty0, af0, ae0, ovf0, unf0}, cnt0,
                 exp_st(), exp_cnt());
      end
      n_checks++;
      if ({full1, empty1, af1, ae1, ovf1, unf1} !== exp_st() ||
          cnt1 !== exp_cnt() || rv1 !== 1'b1 || dout1 !== 16'h0001) begin
        n_errors++;
        $display("FAIL fill_fwft_%0d: got %b cnt %0d head %h expected %b cnt %0d head 0001",
                 i, {full1, empty1, af1, ae1, ovf1, unf1}, cnt1, dout1,
                 exp_st(), exp_cnt());
      end
    end
    cyc(1, 16'hDEAD, 0, 0);
    n_checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || cnt0 !== 4'd8 || cnt1 !== 4'd8 ||
        full0 !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_overflow: got ovf %b/%b cnt %0d/%0d full %b expected 1/1 8/8 1",
               ovf0, ovf1, cnt0, cnt1, full0);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DP; i++) begin
      cyc(0, '0, 1, 0);
      n_checks++;
      if (dout0 !== DW'(i) || rv0 !== 1'b1 || cnt0 !== exp_cnt()) begin
        n_errors++;
        $display("FAIL drain_std_%0d: got %h rv %b cnt %0d expected %h rv 1 cnt %0d",
                 i, dout0, rv0, cnt0, DW'(i), exp_cnt());
      end
      n_checks++;
      if (rv1 !== (q.size() > 0) ||
          (q.size() > 0 && dout1 !== DW'(i + 1))) begin
        n_errors++;
        $display("FAIL drain_fwft_%0d: got %h rv %b expected %h rv %b",
                 i, dout1, rv1, DW'(i + 1), q.size() > 0);
      end
    end
    cyc(0, '0, 1, 0);
    n_checks++;
    if (unf0 !== 1'b1 || unf1 !== 1'b1 || dout0 !== 16'h0008 ||
        rv0 !== 1'b0 || empty0 !== 1'b1 || rv1 !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_underflow: got unf %b/%b dout %h rv %b/%b empty %b expected 1/1 0008 0/0 1",
               unf0, unf1, dout0, rv0, rv1, empty0);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp;
    int n = 0;
    int bad = 0;
    cyc(0, '0, 0, 1);
    for (int round = 0; round < 5; round++) begin
      for (int i = 0; i < DP; i++) cyc(1, DW'(16'h1000 + n + i), 0, 0);
      for (int i = 0; i < DP; i++) begin
        exp = DW'(16'h1000 + n + i);
        if (dout1 !== exp) bad++;
        cyc(0, '0, 1, 0);
        if (dout0 !== exp || rv0 !== 1'b1) bad++;
      end
      n += DP;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL wrap_order: got %0d bad words expected 0", bad);
    end
    n_checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || empty0 !== 1'b1 ||
        ovf0 !== 1'b0 || unf0 !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_end: got cnt %0d/%0d empty %b ovf %b unf %b expected 0/0 1 0 0",
               cnt0, cnt1, empty0, ovf0, unf0);
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, DW'(16'h2000 + i), 0, 0);
    cyc(1, 16'h2003, 1, 0);
    n_checks++;
    if (cnt0 !== 4'd3 || cnt1 !== 4'd3 || dout0 !== 16'h2000 ||
        dout1 !== 16'h2001) begin
      n_errors++;
      $display("FAIL simul_mid: got cnt %0d/%0d dout %h/%h expected 3/3 2000/2001",
               cnt0, cnt1, dout0, dout1);
    end
    while (q.size() < DP) cyc(1, DW'(16'h2100 + q.size()), 0, 0);
    cyc(1, 16'hDEAD, 1, 0);
    n_checks++;
    if (cnt0 !== 4'd7 || ovf0 !== 1'b1 || ovf1 !== 1'b1 ||
        full0 !== 1'b0 || dout0 !== 16'h2001) begin
      n_errors++;
      $display("FAIL simul_full: got cnt %0d ovf %b/%b full %b dout %h expected 7 1/1 0 2001",
               cnt0, ovf0, ovf1, full0, dout0);
    end
    cyc(0, '0, 0, 1);
    cyc(1, 16'h3333, 1, 0);
    n_checks++;
    if (cnt0 !== 4'd1 || cnt1 !== 4'd1 || unf0 !== 1'b1 ||
        rv0 !== 1'b0 || rv1 !== 1'b1 || dout1 !== 16'h3333) begin
      n_errors++;
      $display("FAIL simul_empty: got cnt %0d/%0d unf %b rv %b/%b dout1 %h expected 1/1 1 0/1 3333",
               cnt0, cnt1, unf0, rv0, rv1, dout1);
    end
  endtask

  task automatic test_flush();
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, DW'(16'h4000 + i), 0, 0);
    cyc(1, '0, 0, 0);
    cyc(1, '0, 0, 0);
    cyc(1, '0, 0, 0);
    cyc(1, '0, 0, 0);
    cyc(0, '0, 1, 0);
    n_checks++;
    if (ovf0 !== 1'b1 || cnt0 !== 4'd7 || dout0 !== 16'h4000) begin
      n_errors++;
      $display("FAIL flush_pre: got ovf %b cnt %0d dout %h expected 1 7 4000",
               ovf0, cnt0, dout0);
    end
    cyc(1, 16'h5555, 1, 1);
    n_checks++;
    if ({full0, empty0, af0, ae0, ovf0, unf0} !== 6'b010100 ||
        cnt0 !== 4'd0 || dout0 !== 16'h0000 || rv0 !== 1'b0 ||
        cnt1 !== 4'd0 || rv1 !== 1'b0 || ovf1 !== 1'b0) begin
      n_errors++;
      $display("FAIL flush: got %b cnt %0d/%0d dout %h rv %b/%b expected 010100 0/0 0000 0/0",
               {full0, empty0, af0, ae0, ovf0, unf0}, cnt0, cnt1, dout0, rv0, rv1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cyc(1, DW'(16'h6000 + i), 0, 0);
    cyc(1, 16'h6004, 1, 0);
    w_en = 1;
    data_in = 16'h6005;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    w_en = 0;
    n_checks++;
    if ({full0, empty0, af0, ae0, ovf0, unf0, rv0, cnt0, dout0} !==
        {6'b010100, 1'b0, 4'd0, 16'h0} ||
        {empty1, rv1, cnt1} !== {1'b1, 1'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL async_reset: got %b %b %0d %h / %b %b %0d expected 010100 0 0 0000 / 1 0 0",
               {full0, empty0, af0, ae0, ovf0, unf0}, rv0, cnt0, dout0,
               empty1, rv1, cnt1);
    end
    release_reset();
  endtask

  task automatic test_fwft_latency();
    n_checks++;
    if (rv1 !== 1'b0 || empty1 !== 1'b1) begin
      n_errors++;
      $display("FAIL fwft_idle: got rv %b empty %b expected 0 1", rv1, empty1);
    end
    cyc(1, 16'hBEEF, 0, 0);
    n_checks++;
    if (rv1 !== 1'b1 || dout1 !== 16'hBEEF || empty1 !== 1'b0 ||
        rv0 !== 1'b0) begin
      n_errors++;
      $display("FAIL fwft_latency: got rv %b dout %h empty %b std_rv %b expected 1 beef 0 0",
               rv1, dout1, empty1, rv0);
    end
  endtask

  task automatic test_random();
    bit w, r, c;
    logic [DW-1:0] d;
    for (int k = 0; k < 600; k++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 2);
      d = DW'($urandom);
      cyc(w, d, r, c);
      n_checks++;
      if ({full0, empty0, af0, ae0, ovf0, unf0} !== exp_st() ||
          cnt0 !== exp_cnt() || rv0 !== m_rv0 || dout0 !== m_dout0) begin
        n_errors++;
        $display("FAIL rand_std_%0d: got %b cnt %0d rv %b dout %h expected %b cnt %0d rv %b dout %h",
                 k, {full0, empty0, af0, ae0, ovf0, unf0}, cnt0, rv0, dout0,
                 exp_st(), exp_cnt(), m_rv0, m_dout0);
      end
      n_checks++;
      if ({full1, empty1, af1, ae1, ovf1, unf1} !== exp_st() ||
          cnt1 !== exp_cnt() || rv1 !== (q.size() > 0) ||
          (q.size() > 0 && dout1 !== q[0])) begin
        n_errors++;
        $display("FAIL rand_fwft_%0d: got %b cnt %0d rv %b dout %h expected %b cnt %0d",
                 k, {full1, empty1, af1, ae1, ovf1, unf1}, cnt1, rv1, dout1,
                 exp_st(), exp_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_fwft_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
